cache_replace: RTL and testbench
================================

CACHE_REPLACE -- requirements
Module: cache_replace

Interface
REQ-001 SHALL have parameters: NUMWAYS, default 4, ways per set (power of 2, 2..32); NUMLINES, default 128, sets; SETLEN, default $clog2(NUMLINES), set index width; POLICY, default 0, 0=tree pseudo-LRU, 1=LFSR pseudo-random.
REQ-002 SHALL have ports, one per line:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- CacheEn  in  1  enables state read/write
- FlushStage  in  1  suppresses invalidate start
- HitWay  in  NUMWAYS  one-hot hit way
- ValidWay  in  NUMWAYS  valid bits of the addressed set
- CacheSetTag  in  SETLEN  set index to read
- PAdr  in  SETLEN  set index to write
- LRUWriteEn  in  1  update replacement state
- SetValid  in  1  fill, so update uses the victim way
- InvalidateCache  in  1  start clear sweep
- LockWay  in  NUMWAYS  ways excluded from victim choice (present only with the macro)
- VictimWay  out  NUMWAYS  one-hot victim
- NoVictim  out  1  all ways locked (present only with the macro)
- Busy  out  1  sweep in progress
REQ-003 Clock SHALL be clk; reset SHALL be reset_n, asynchronous, active-low; both SHALL be the only clock and reset.

Function
REQ-004 SHALL hold per-set state of NUMWAYS-1 bits in heap order: node k has children 2k+1 and 2k+2, with node 0 as root; bit 0 means victim in lower-index half; bit 1 means upper half.
REQ-005 Read: CurrLRU SHALL register the state of CacheSetTag one cycle after any cycle with CacheEn=1; CurrLRU SHALL hold when CacheEn=0.
REQ-006 Bypass: if LRUWriteEn & (PAdr==CacheSetTag) in the same cycle, CurrLRU SHALL load the newly written value.
REQ-007 Update Way SHALL be SetValid ? encoded VictimWay : encoded HitWay; every node on the path to Way SHALL be set to point away from Way; off-path nodes SHALL be unchanged; the write SHALL go to PAdr.
REQ-008 Victim selection SHALL be combinational from CurrLRU, ValidWay and the LFSR, with this priority: (a) lowest-index invalid way; (b) POLICY=0: walk the tree from the root; POLICY=1: use the low log2(NUMWAYS) bits of the LFSR.
REQ-009 LFSR SHALL be 16 bits, polynomial x^16+x^15+x^13+x^4+1, shifting toward the LSB with feedback into bit 15.
REQ-010 LFSR SHALL advance on each clk with CacheEn & LRUWriteEn & SetValid, and never be zero.
REQ-011 VictimWay SHALL always be exactly one-hot.
REQ-012 Sweep FSM SHALL have states IDLE and SWEEP.
- IDLE->SWEEP when InvalidateCache & ~FlushStage; the counter SHALL be set to 0.
- In SWEEP, set[counter] SHALL be cleared per cycle and the counter SHALL increment; at NUMLINES-1, SHALL return to IDLE.
- Busy SHALL equal (state==SWEEP).
REQ-013 During SWEEP, LRUWriteEn SHALL be ignored and CurrLRU SHALL read as 0.
REQ-014 InvalidateCache & ~FlushStage during SWEEP SHALL restart the counter at 0.
REQ-015 InvalidateCache with FlushStage=1 SHALL have no effect.

Reset
REQ-016 reset_n low SHALL force: FSM=IDLE, counter=0, Busy=0, CurrLRU=0, LFSR=16'h0001, all set state=0; this SHALL apply immediately, including mid-sweep.
REQ-017 After reset with ValidWay all ones and POLICY=0, VictimWay SHALL be 1 (way 0); with POLICY=1, VictimWay SHALL be way 1.

Configuration
REQ-018 Macro CACHE_REPLACE_LOCK_EN SHALL control way locking.
- Defined: LockWay and NoVictim SHALL exist; locked ways SHALL be excluded from step (a).
- Defined: if the step (b) choice is locked, the next unlocked way upward with wrap SHALL be chosen.
- Defined: if all ways are locked, NoVictim=1 and VictimWay=1, and LRUWriteEn with SetValid SHALL not write.
- Undefined: LockWay and NoVictim SHALL be absent, and behaviour SHALL be as if LockWay=0.

Verification
REQ-019 NUMWAYS=4, POLICY=0, after reset, ValidWay=4'b1111 -> VictimWay=4'b0001, Busy=0.
REQ-020 HitWay=4'b0001, LRUWriteEn, PAdr=CacheSetTag=3 -> next cycle CurrLRU=3'b011, VictimWay=4'b0100; same-cycle bypass checked.
REQ-021 ValidWay=4'b1011 with any CurrLRU -> VictimWay=4'b0100.
REQ-022 NUMLINES=128, InvalidateCache pulse -> Busy high exactly 128 cycles, all sets read 0 afterward; a second pulse at cycle 50 -> Busy 178 cycles total; reset_n low at cycle 20 -> Busy=0 immediately.
REQ-023 With CACHE_REPLACE_LOCK_EN, state as in REQ-020 and LockWay=4'b0100 -> VictimWay=4'b1000; LockWay=4'b1111 -> NoVictim=1, VictimWay=4'b0001.
REQ-024 POLICY=1, ValidWay=4'b1111, three fills -> LFSR 0001->8000->4000->2000, VictimWay 0010, 0001, 0001, 0001.

Source files
------------

// File: rtl/cache_replace.sv
// cache_replace: per-set tree pseudo-LRU or LFSR victim selection with a set-clearing invalidate sweep.
// Define CACHE_REPLACE_LOCK_EN to add way locking (LockWay input, NoVictim output).
module cache_replace #(
  parameter int NUMWAYS  = 4,
  parameter int NUMLINES = 128,
  parameter int SETLEN   = $clog2(NUMLINES),
  parameter int POLICY   = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               CacheEn,
  input  logic               FlushStage,
  input  logic [NUMWAYS-1:0] HitWay,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic [SETLEN-1:0]  CacheSetTag,
  input  logic [SETLEN-1:0]  PAdr,
  input  logic               LRUWriteEn,
  input  logic               SetValid,
  input  logic               InvalidateCache,
`ifdef CACHE_REPLACE_LOCK_EN
  input  logic [NUMWAYS-1:0] LockWay,
  output logic               NoVictim,
`endif
  output logic [NUMWAYS-1:0] VictimWay,
  output logic               Busy
);
  localparam int LOGW = $clog2(NUMWAYS);
  localparam int NB   = NUMWAYS - 1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state_q, state_d;
  logic [SETLEN-1:0]   cnt_q, cnt_d;
  logic [NB-1:0]       lru_q [NUMLINES];
  logic [NB-1:0]       curr_q, curr_d, wr_val;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [NUMWAYS-1:0]  lock;
  logic [LOGW-1:0]     inv_way, tree_way, pick_way, victim, hit_way, upd_way;
  logic                has_inv, all_locked, we;

`ifdef CACHE_REPLACE_LOCK_EN
  assign lock     = LockWay;
  assign NoVictim = all_locked;
`else
  assign lock = '0;
`endif

  assign all_locked = &lock;
  assign Busy       = (state_q == SWEEP);
  assign we         = CacheEn & LRUWriteEn & ~Busy & ~(SetValid & all_locked);

  // Victim: lowest unlocked invalid way, else policy choice bumped upward past locked ways.
  always_comb begin
    logic [NUMWAYS-1:0] pad;
    int n;
    pad      = {1'b0, curr_q};
    n        = 0;
    has_inv  = 1'b0;
    inv_way  = '0;
    tree_way = '0;
    for (int w = NUMWAYS - 1; w >= 0; w--)
      if (!ValidWay[w] && !lock[w]) begin
        has_inv = 1'b1;
        inv_way = LOGW'(w);
      end
    for (int l = 0; l < LOGW; l++) begin
      tree_way[LOGW-1-l] = pad[n[LOGW-1:0]];
      n = 2 * n + 1 + int'(pad[n[LOGW-1:0]]);
    end
    pick_way = has_inv ? inv_way : (POLICY == 1) ? lfsr_q[LOGW-1:0] : tree_way;
    victim   = pick_way;
    if (lock[pick_way])
      for (int i = NUMWAYS - 1; i >= 1; i--)
        if (!lock[LOGW'(int'(pick_way) + i)]) victim = LOGW'(int'(pick_way) + i);
    if (all_locked) victim = '0;
    VictimWay = '0;
    VictimWay[victim] = 1'b1;
  end

  // Path nodes of upd_way are flipped to point away from it; others keep their value.
  always_comb begin
    logic [NUMWAYS-1:0] wpad;
    int n;
    n       = 0;
    hit_way = '0;
    for (int w = 0; w < NUMWAYS; w++)
      if (HitWay[w]) hit_way |= LOGW'(w);
    upd_way = SetValid ? victim : hit_way;
    wpad    = {1'b0, lru_q[PAdr]};
    for (int l = 0; l < LOGW; l++) begin
      n = (1 << l) - 1 + int'(upd_way >> (LOGW - l));
      wpad[n[LOGW-1:0]] = ~upd_way[LOGW-1-l];
    end
    wr_val = wpad[NB-1:0];
  end

  always_comb begin
    curr_d  = Busy ? '0 : !CacheEn ? curr_q : (we && PAdr == CacheSetTag) ? wr_val : lru_q[CacheSetTag];
    lfsr_d  = (CacheEn & LRUWriteEn & SetValid) ? {lfsr_q[0] ^ lfsr_q[1] ^ lfsr_q[3] ^ lfsr_q[12], lfsr_q[15:1]} : lfsr_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (InvalidateCache && !FlushStage) begin
      state_d = SWEEP;
      cnt_d   = '0;
    end else if (state_q == SWEEP) begin
      cnt_d   = cnt_q + SETLEN'(1);
      state_d = (cnt_q == SETLEN'(NUMLINES - 1)) ? IDLE : SWEEP;
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      curr_q  <= '0;
      lfsr_q  <= 16'h0001;
      for (int s = 0; s < NUMLINES; s++) lru_q[s] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      curr_q  <= curr_d;
      lfsr_q  <= lfsr_d;
      if (Busy) lru_q[cnt_q] <= '0;
      else if (we) lru_q[PAdr] <= wr_val;
    end
endmodule

// File: tb/tb_cache_replace.sv
// tb_cache_replace: two instances (tree PLRU and LFSR policy) checked against a set-level model.
module tb_cache_replace;
  localparam int NW = 4;
  localparam int NL = 128;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       CacheEn = 1'b0, FlushStage = 1'b0, LRUWriteEn = 1'b0, SetValid = 1'b0, InvalidateCache = 1'b0;
  logic [3:0] HitWay = 4'b0001, ValidWay = 4'b1111, LockWay = 4'b0000;
  logic [6:0] CacheSetTag = '0, PAdr = '0;
  logic [3:0] vic0, vic1;
  logic       bsy0, bsy1, nov0, nov1;

  int n_cmp = 0, n_err = 0;
  bit chk_on = 0;

  int         lru_m [2][NL];
  int         curr_m [2];
  logic [15:0] lfsr_m;
  int         rem_m, idx_m;

  always #5 clk = ~clk;

`ifdef CACHE_REPLACE_LOCK_EN
  cache_replace #(.NUMWAYS(NW), .NUMLINES(NL), .POLICY(0)) u0 (
    .clk(clk), .reset_n(reset_n), .CacheEn(CacheEn), .FlushStage(FlushStage), .HitWay(HitWay),
    .ValidWay(ValidWay), .CacheSetTag(CacheSetTag), .PAdr(PAdr), .LRUWriteEn(LRUWriteEn),
    .SetValid(SetValid), .InvalidateCache(InvalidateCache), .LockWay(LockWay), .NoVictim(nov0),
    .VictimWay(vic0), .Busy(bsy0));
  cache_replace #(.NUMWAYS(NW), .NUMLINES(NL), .POLICY(1)) u1 (
    .clk(clk), .reset_n(reset_n), .CacheEn(CacheEn), .FlushStage(FlushStage), .HitWay(HitWay),
    .ValidWay(ValidWay), .CacheSetTag(CacheSetTag), .PAdr(PAdr), .LRUWriteEn(LRUWriteEn),
    .SetValid(SetValid), .InvalidateCache(InvalidateCache), .LockWay(LockWay), .NoVictim(nov1),
    .VictimWay(vic1), .Busy(bsy1));
  function automatic logic [3:0] locks(); return LockWay; endfunction
`else
  cache_replace #(.NUMWAYS(NW), .NUMLINES(NL), .POLICY(0)) u0 (
    .clk(clk), .reset_n(reset_n), .CacheEn(CacheEn), .FlushStage(FlushStage), .HitWay(HitWay),
    .ValidWay(ValidWay), .CacheSetTag(CacheSetTag), .PAdr(PAdr), .LRUWriteEn(LRUWriteEn),
    .SetValid(SetValid), .InvalidateCache(InvalidateCache), .VictimWay(vic0), .Busy(bsy0));
  cache_replace #(.NUMWAYS(NW), .NUMLINES(NL), .POLICY(1)) u1 (
    .clk(clk), .reset_n(reset_n), .CacheEn(CacheEn), .FlushStage(FlushStage), .HitWay(HitWay),
    .ValidWay(ValidWay), .CacheSetTag(CacheSetTag), .PAdr(PAdr), .LRUWriteEn(LRUWriteEn),
    .SetValid(SetValid), .InvalidateCache(InvalidateCache), .VictimWay(vic1), .Busy(bsy1));
  assign nov0 = 1'b0;
  assign nov1 = 1'b0;
  function automatic logic [3:0] locks(); return 4'b0000; endfunction
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Victim index from the spec's rules; tree node for level l is (2^l - 1) + path prefix.
  function automatic int pick(int p, int cur, logic [3:0] vld, int lf, logic [3:0] lk);
    int c;
    if (lk == 4'b1111) return 0;
    for (int w = 0; w < NW; w++) if (!vld[w] && !lk[w]) return w;
    c = 0;
    if (p == 0) for (int l = 0; l < 2; l++) c = c * 2 + ((cur >> ((1 << l) - 1 + c)) & 1);
    else c = lf % NW;
    for (int i = 0; i < NW; i++) if (!lk[(c + i) % NW]) return (c + i) % NW;
    return 0;
  endfunction

  function automatic int upd(int old, int way);
    int r, n;
    r = old;
    for (int l = 0; l < 2; l++) begin
      n = (1 << l) - 1 + (way >> (2 - l));
      if (((way >> (1 - l)) & 1) != 0) r = r & ~(1 << n);
      else r = r | (1 << n);
    end
    return r;
  endfunction

  function automatic int enc(logic [3:0] oh);
    for (int w = 0; w < NW; w++) if (oh[w]) return w;
    return 0;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      curr_m[p] = 0;
      for (int s = 0; s < NL; s++) lru_m[p][s] = 0;
    end
    lfsr_m = 16'h0001;
    rem_m  = 0;
    idx_m  = 0;
  endtask

  task automatic model_edge();
    bit busy, we;
    int v, way, nv;
    logic [3:0] lk;
    lk   = locks();
    busy = rem_m > 0;
    for (int p = 0; p < 2; p++) begin
      v   = pick(p, curr_m[p], ValidWay, int'(lfsr_m), lk);
      way = SetValid ? v : enc(HitWay);
      we  = CacheEn && LRUWriteEn && !busy && !(SetValid && lk == 4'b1111);
      nv  = upd(lru_m[p][PAdr], way);
      if (busy) curr_m[p] = 0;
      else if (CacheEn) curr_m[p] = (we && PAdr == CacheSetTag) ? nv : lru_m[p][CacheSetTag];
      if (busy) lru_m[p][idx_m] = 0;
      else if (we) lru_m[p][PAdr] = nv;
    end
    if (CacheEn && LRUWriteEn && SetValid)
      lfsr_m = {lfsr_m[0] ^ lfsr_m[1] ^ lfsr_m[3] ^ lfsr_m[12], lfsr_m[15:1]};
    if (busy) begin
      idx_m++;
      rem_m--;
    end
    if (InvalidateCache && !FlushStage) begin
      rem_m = NL;
      idx_m = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  always @(negedge clk) if (chk_on) begin
    logic [3:0] lk;
    lk = locks();
    check("victim_p0", vic0, 4'b0001 << pick(0, curr_m[0], ValidWay, int'(lfsr_m), lk));
    check("victim_p1", vic1, 4'b0001 << pick(1, curr_m[1], ValidWay, int'(lfsr_m), lk));
    check("busy_p0", bsy0, rem_m > 0);
    check("busy_p1", bsy1, rem_m > 0);
`ifdef CACHE_REPLACE_LOCK_EN
    check("novictim_p0", nov0, lk == 4'b1111);
    check("novictim_p1", nov1, lk == 4'b1111);
`endif
  end

  initial begin
    int n;
    do_reset();
    chk_on = 1;
    check("rst_victim_p0", vic0, 4'b0001);
    check("rst_victim_p1", vic1, 4'b0010);
    check("rst_busy", bsy0, 1'b0);

    CacheEn = 1; HitWay = 4'b0001; LRUWriteEn = 1; PAdr = 3; CacheSetTag = 3;
    step();
    LRUWriteEn = 0;
    check("bypass_victim_p0", vic0, 4'b0100);
    check("bypass_victim_p1", vic1, 4'b0010);
    ValidWay = 4'b1011; #1;
    check("invalid_way2_p0", vic0, 4'b0100);
    check("invalid_way2_p1", vic1, 4'b0100);
    ValidWay = 4'b1110; #1;
    check("invalid_way0_p0", vic0, 4'b0001);
    ValidWay = 4'b1111;
`ifdef CACHE_REPLACE_LOCK_EN
    LockWay = 4'b0100; #1;
    check("lock_skip_p0", vic0, 4'b1000);
    LockWay = 4'b1111; #1;
    check("lock_all_nov", nov0, 1'b1);
    check("lock_all_victim", vic0, 4'b0001);
    LockWay = 4'b0000;
`endif
    step();

    do_reset();
    CacheEn = 1; LRUWriteEn = 1; SetValid = 1; PAdr = 5; CacheSetTag = 5; #1;
    check("lfsr_fill0", vic1, 4'b0010);
    step(); check("lfsr_fill1", vic1, 4'b0001);
    step(); check("lfsr_fill2", vic1, 4'b0001);
    step(); check("lfsr_fill3", vic1, 4'b0001);
    SetValid = 0; HitWay = 4'b0001; PAdr = 7; CacheSetTag = 7;
    step();
    LRUWriteEn = 0;

    InvalidateCache = 1; FlushStage = 1; step();
    check("flush_blocks", bsy0, 1'b0);
    FlushStage = 0; step();
    InvalidateCache = 0;
    n = 0;
    for (int i = 0; i < 300 && bsy0; i++) begin n++; step(); end
    check("sweep_len", n, 128);
    step(); #1;
    check("cleared_set7", vic0, 4'b0001);

    InvalidateCache = 1; step(); InvalidateCache = 0;
    n = 0;
    for (int i = 1; i < 400 && bsy0; i++) begin
      n++;
      InvalidateCache = (i == 50);
      step();
    end
    InvalidateCache = 0;
    check("restart_len", n, 178);

    InvalidateCache = 1; step(); InvalidateCache = 0;
    repeat (20) step();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_busy_p0", bsy0, 1'b0);
    check("rst_mid_busy_p1", bsy1, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      CacheEn         = $urandom_range(0, 4) != 0;
      LRUWriteEn      = $urandom_range(0, 1);
      SetValid        = $urandom_range(0, 1);
      FlushStage      = $urandom_range(0, 1);
      InvalidateCache = $urandom_range(0, 199) == 0;
      HitWay          = 4'b0001 << $urandom_range(0, 3);
      ValidWay        = ($urandom_range(0, 3) != 0) ? 4'b1111 : 4'($urandom_range(0, 15));
      LockWay         = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      PAdr            = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
      CacheSetTag     = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
      step();
    end
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
